// File: rtl/stage_mem_load_tracker_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stage_mem_load_tracker_pkg
//  Purpose  : Shared types and constants for the MEM-stage load tracker.
//             Holds the queue entry layout, the default queue depth and a
//             helper that derives a register-index width from a register
//             count.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package stage_mem_load_tracker_pkg;

    localparam int unsigned DEF_REG_NUM = 32;
    localparam int unsigned DEF_MAX_OUT = 4;

    // Register-index width for a register file of n entries; never below 1.
    function automatic int unsigned REG_IDX_W(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Entry rd width. Trackers built with REG_NUM up to DEF_REG_NUM fit.
    localparam int unsigned RW = REG_IDX_W(DEF_REG_NUM);

    typedef struct packed {
        logic          valid;
        logic [RW-1:0] rd;
    } load_entry_t;

endpackage
`default_nettype wire

// File: rtl/stage_mem_load_tracker_queue.sv
`default_nettype none
// ============================================================================
//  Module   : load_queue
//  Purpose  : Generic in-order circular buffer with push/pop, occupancy
//             count, full/empty flags and a flat view of every slot.
//  Ports    : clk, rst_n        - clock, async active-low reset
//             clear_i           - drop all entries (priority over push/pop)
//             push_i/push_data_i- enqueue request, ignored when full
//             pop_i             - dequeue request, ignored when empty
//             full_o/empty_o    - occupancy flags from registered state
//             count_o           - number of valid entries
//             head_data_o       - data at read pointer, 0 when slot invalid
//             ent_valid_o       - per-slot valid bits
//             ent_data_o        - per-slot data, slot k at [k*DATA_W +: DATA_W]
//  Revision : 1.0 - initial release
// ============================================================================
module load_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_i,
    input  logic                       push_i,
    input  logic [DATA_W-1:0]          push_data_i,
    input  logic                       pop_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [DATA_W-1:0]          head_data_o,
    output logic [DEPTH-1:0]           ent_valid_o,
    output logic [DEPTH*DATA_W-1:0]    ent_data_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH+1);

    logic [DEPTH-1:0]             valid_q, valid_d;
    logic [DEPTH-1:0][DATA_W-1:0] data_q,  data_d;
    logic [PTR_W-1:0]             wptr_q,  wptr_d;
    logic [PTR_W-1:0]             rptr_q,  rptr_d;
    logic [CNT_W-1:0]             count_q, count_d;

    logic w_push_acc;
    logic w_pop_acc;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

    // Acceptance uses registered occupancy only: a pop in the same cycle
    // never makes room for a push in that cycle.
    assign w_push_acc = push_i && !full_o;
    assign w_pop_acc  = pop_i  && !empty_o;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (clear_i) begin
            valid_d = '0;
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // Push and pop never hit the same slot: push needs a free slot,
            // pop needs an occupied one.
            if (w_push_acc) begin
                valid_d[wptr_q] = 1'b1;
                data_d[wptr_q]  = push_data_i;
                wptr_d          = wptr_q + PTR_W'(1);
            end
            if (w_pop_acc) begin
                valid_d[rptr_q] = 1'b0;
                rptr_d          = rptr_q + PTR_W'(1);
            end
            case ({w_push_acc, w_pop_acc})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            data_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign count_o     = count_q;
    assign head_data_o = valid_q[rptr_q] ? data_q[rptr_q] : '0;
    assign ent_valid_o = valid_q;
    assign ent_data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/stage_mem_load_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : stage_mem_load_tracker
//  Purpose  : Records every outstanding data-memory load and raises the
//             ID-stage load-use stall while an ID source operand is the
//             destination of a load that has not yet returned.
//  Ports    : clk, rst_n              - clock, async active-low reset
//             flush                   - discard all outstanding loads
//             issue_valid/issue_rd    - load issued from EX/MEM
//             issue_ready             - a free slot exists
//             resp_valid              - oldest load completes
//             resp_rd                 - writeback target of oldest load
//             has_rsN/rsN_addr (N=1..3) - ID operand usage and address
//             load_stall              - hold ID
//             pending_mask            - registers with an outstanding load
//             count                   - outstanding load count
//             resp_err                - sticky: response seen while empty
//  Revision : 1.0 - initial release
// ============================================================================
module stage_mem_load_tracker
    import stage_mem_load_tracker_pkg::*;
#(
    parameter int unsigned REG_NUM = DEF_REG_NUM,
    parameter int unsigned MAX_OUT = DEF_MAX_OUT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         issue_valid,
    input  logic [$clog2(REG_NUM)-1:0]   issue_rd,
    output logic                         issue_ready,
    input  logic                         resp_valid,
    output logic [$clog2(REG_NUM)-1:0]   resp_rd,
    input  logic                         has_rs1,
    input  logic                         has_rs2,
    input  logic                         has_rs3,
    input  logic [$clog2(REG_NUM)-1:0]   rs1_addr,
    input  logic [$clog2(REG_NUM)-1:0]   rs2_addr,
    input  logic [$clog2(REG_NUM)-1:0]   rs3_addr,
    output logic                         load_stall,
    output logic [REG_NUM-1:0]           pending_mask,
    output logic [$clog2(MAX_OUT+1)-1:0] count,
    output logic                         resp_err
);

    localparam int unsigned IW = $clog2(REG_NUM);
    localparam int unsigned CW = $clog2(MAX_OUT+1);

    logic                    w_full;
    logic                    w_empty;
    logic [CW-1:0]           w_count;
    logic [RW-1:0]           w_head_rd;
    logic [MAX_OUT-1:0]      w_ent_valid;
    logic [MAX_OUT*RW-1:0]   w_ent_data;
    load_entry_t             w_entries [MAX_OUT];
    logic [REG_NUM-1:0]      w_mask;
    logic                    w_hit1, w_hit2, w_hit3;
    logic                    resp_err_q, resp_err_d;

    load_queue #(
        .DEPTH  (MAX_OUT),
        .DATA_W (RW)
    ) u_queue (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (flush),
        .push_i      (issue_valid),
        .push_data_i (RW'(issue_rd)),
        .pop_i       (resp_valid),
        .full_o      (w_full),
        .empty_o     (w_empty),
        .count_o     (w_count),
        .head_data_o (w_head_rd),
        .ent_valid_o (w_ent_valid),
        .ent_data_o  (w_ent_data)
    );

    generate
        for (genvar k = 0; k < MAX_OUT; k++) begin : g_entry
            assign w_entries[k] = {w_ent_valid[k], w_ent_data[k*RW +: RW]};
        end
    endgenerate

    // The mask is the OR over valid entries, so a register loaded twice
    // stays pending until its last load retires. Bit 0 is never set: x0
    // loads only hold a slot to preserve response ordering.
    always_comb begin
        w_mask = '0;
        for (int r = 1; r < int'(REG_NUM); r++) begin
            for (int k = 0; k < int'(MAX_OUT); k++) begin
                if (w_entries[k].valid && (w_entries[k].rd == RW'(r))) begin
                    w_mask[r] = 1'b1;
                end
            end
        end
    end

    assign w_hit1 = has_rs1 && (rs1_addr != '0) && w_mask[rs1_addr];
    assign w_hit2 = has_rs2 && (rs2_addr != '0) && w_mask[rs2_addr];
    assign w_hit3 = has_rs3 && (rs3_addr != '0) && w_mask[rs3_addr];

    // A response with nothing outstanding is ignored by the queue but
    // recorded here; flush does not clear it.
    always_comb begin
        resp_err_d = resp_err_q;
        if (resp_valid && w_empty) begin
            resp_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_err_q <= 1'b0;
        end else begin
            resp_err_q <= resp_err_d;
        end
    end

    assign issue_ready  = !w_full;
    assign count        = w_count;
    assign resp_rd      = IW'(w_head_rd);
    assign pending_mask = w_mask;
    assign load_stall   = w_hit1 || w_hit2 || w_hit3;
    assign resp_err     = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_stage_mem_load_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stage_mem_load_tracker
//  Purpose  : Self-checking bench for stage_mem_load_tracker. A scoreboard
//             queue receives the rd of every accepted issue and is popped
//             and compared against resp_rd as responses are applied.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stage_mem_load_tracker;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ready;
    logic        resp_valid;
    logic [4:0]  resp_rd;
    logic        has_rs1, has_rs2, has_rs3;
    logic [4:0]  rs1_addr, rs2_addr, rs3_addr;
    logic        load_stall;
    logic [31:0] pending_mask;
    logic [2:0]  count;
    logic        resp_err;

    int          errors = 0;
    int          checks = 0;
    logic [4:0]  sb [$];
    logic        exp_err = 1'b0;

    stage_mem_load_tracker #(.REG_NUM(32), .MAX_OUT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .issue_valid  (issue_valid),
        .issue_rd     (issue_rd),
        .issue_ready  (issue_ready),
        .resp_valid   (resp_valid),
        .resp_rd      (resp_rd),
        .has_rs1      (has_rs1),
        .has_rs2      (has_rs2),
        .has_rs3      (has_rs3),
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .rs3_addr     (rs3_addr),
        .load_stall   (load_stall),
        .pending_mask (pending_mask),
        .count        (count),
        .resp_err     (resp_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [31:0] exp_mask();
        logic [31:0] m;
        m = '0;
        foreach (sb[i]) if (sb[i] != 5'd0) m[sb[i]] = 1'b1;
        return m;
    endfunction

    // One clock cycle: drive inputs, advance the reference model at the
    // edge, then return #1 after the falling edge with inputs idle.
    task automatic tick(input bit iv, input logic [4:0] ird, input bit rv, input bit fl);
        int         sz;
        logic [4:0] tmp;
        issue_valid = iv;
        issue_rd    = ird;
        resp_valid  = rv;
        flush       = fl;
        sz          = sb.size();
        @(posedge clk);
        if (rv && sz == 0) exp_err = 1'b1;
        if (fl) begin
            sb.delete();
        end else begin
            if (rv && sz > 0) tmp = sb.pop_front();
            if (iv && sz < 4) sb.push_back(ird);
        end
        @(negedge clk);
        issue_valid = 1'b0;
        issue_rd    = '0;
        resp_valid  = 1'b0;
        flush       = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", issue_ready); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (pending_mask !== 32'h0) begin errors++; $display("FAIL reset_mask: got %h want 0", pending_mask); end
        checks++; if (resp_rd !== 5'd0) begin errors++; $display("FAIL reset_resp_rd: got %0d want 0", resp_rd); end
        checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", resp_err); end
        has_rs1 = 1'b1; rs1_addr = 5'd5; #1;
        checks++; if (load_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", load_stall); end
        has_rs1 = 1'b0;
    endtask

    task automatic test_issue_use();
        tick(1'b1, 5'd5, 1'b0, 1'b0);
        has_rs1 = 1'b1; rs1_addr = 5'd5; #1;
        checks++; if (load_stall !== 1'b1) begin errors++; $display("FAIL use_stall_c1: got %b want 1", load_stall); end
        checks++; if (pending_mask !== exp_mask()) begin errors++; $display("FAIL use_mask: got %h want %h", pending_mask, exp_mask()); end
        tick(1'b0, 5'd0, 1'b0, 1'b0);
        checks++; if (load_stall !== 1'b1) begin errors++; $display("FAIL use_stall_c2: got %b want 1", load_stall); end
        checks++; if (resp_rd !== sb[0]) begin errors++; $display("FAIL use_resp_rd: got %0d want %0d", resp_rd, sb[0]); end
        tick(1'b0, 5'd0, 1'b1, 1'b0);
        checks++; if (load_stall !== 1'b0) begin errors++; $display("FAIL use_stall_c3: got %b want 0", load_stall); end
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL use_count: got %0d want 0", count); end
        has_rs1 = 1'b0;
    endtask

    task automatic test_fill_drain();
        for (int round = 0; round < 3; round++) begin
            for (int i = 1; i <= 4; i++) tick(1'b1, 5'(i), 1'b0, 1'b0);
            checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count r%0d: got %0d want 4", round, count); end
            checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL fill_ready r%0d: got %b want 0", round, issue_ready); end
            checks++; if (pending_mask !== exp_mask()) begin errors++; $display("FAIL fill_mask r%0d: got %h want %h", round, pending_mask, exp_mask()); end
            tick(1'b1, 5'd6, 1'b0, 1'b0);
            checks++; if (count !== 3'd4 || pending_mask[6] !== 1'b0) begin errors++; $display("FAIL fill_drop r%0d: got count %0d bit6 %b want 4/0", round, count, pending_mask[6]); end
            checks++; if (resp_rd !== sb[0]) begin errors++; $display("FAIL fill_resp_rd r%0d: got %0d want %0d", round, resp_rd, sb[0]); end
            tick(1'b1, 5'd6, 1'b1, 1'b0);
            checks++; if (count !== 3'd3) begin errors++; $display("FAIL full_issue_resp r%0d: got %0d want 3", round, count); end
            checks++; if (pending_mask !== exp_mask()) begin errors++; $display("FAIL full_mask r%0d: got %h want %h", round, pending_mask, exp_mask()); end
            for (int j = 0; j < 8 && sb.size() > 0; j++) begin
                checks++; if (resp_rd !== sb[0]) begin errors++; $display("FAIL drain_rd r%0d: got %0d want %0d", round, resp_rd, sb[0]); end
                tick(1'b0, 5'd0, 1'b1, 1'b0);
            end
            checks++; if (count !== 3'd0 || issue_ready !== 1'b1) begin errors++; $display("FAIL drain_done r%0d: got count %0d ready %b want 0/1", round, count, issue_ready); end
        end
    endtask

    task automatic test_dup_x0();
        tick(1'b1, 5'd7, 1'b0, 1'b0);
        tick(1'b1, 5'd7, 1'b0, 1'b0);
        has_rs3 = 1'b1; rs3_addr = 5'd7; #1;
        checks++; if (load_stall !== 1'b1) begin errors++; $display("FAIL dup_stall: got %b want 1", load_stall); end
        checks++; if (count !== 3'd2 || pending_mask !== exp_mask()) begin errors++; $display("FAIL dup_state: got count %0d mask %h want 2/%h", count, pending_mask, exp_mask()); end
        checks++; if (resp_rd !== sb[0]) begin errors++; $display("FAIL dup_resp_rd: got %0d want %0d", resp_rd, sb[0]); end
        tick(1'b0, 5'd0, 1'b1, 1'b0);
        checks++; if (pending_mask[7] !== 1'b1 || count !== 3'd1) begin errors++; $display("FAIL dup_first: got bit7 %b count %0d want 1/1", pending_mask[7], count); end
        tick(1'b0, 5'd0, 1'b1, 1'b0);
        checks++; if (pending_mask[7] !== 1'b0 || load_stall !== 1'b0) begin errors++; $display("FAIL dup_second: got bit7 %b stall %b want 0/0", pending_mask[7], load_stall); end
        has_rs3 = 1'b0;
        tick(1'b1, 5'd0, 1'b0, 1'b0);
        has_rs2 = 1'b1; rs2_addr = 5'd0; #1;
        checks++; if (count !== 3'd1 || pending_mask !== 32'h0) begin errors++; $display("FAIL x0_state: got count %0d mask %h want 1/0", count, pending_mask); end
        checks++; if (load_stall !== 1'b0) begin errors++; $display("FAIL x0_stall: got %b want 0", load_stall); end
        checks++; if (resp_rd !== sb[0]) begin errors++; $display("FAIL x0_resp_rd: got %0d want %0d", resp_rd, sb[0]); end
        tick(1'b0, 5'd0, 1'b1, 1'b0);
        has_rs2 = 1'b0;
        checks++; if (count !== 3'd0) begin errors++; $display("FAIL x0_drain: got %0d want 0", count); end
    endtask

    task automatic test_flush();
        tick(1'b1, 5'd3, 1'b0, 1'b0);
        tick(1'b1, 5'd9, 1'b0, 1'b0);
        tick(1'b1, 5'd10, 1'b0, 1'b0);
        checks++; if (count !== 3'd3) begin errors++; $display("FAIL flush_pre: got %0d want 3", count); end
        tick(1'b1, 5'd11, 1'b0, 1'b1);
        has_rs1 = 1'b1; rs1_addr = 5'd9; has_rs3 = 1'b1; rs3_addr = 5'd11; #1;
        checks++; if (count !== 3'd0 || pending_mask !== 32'h0) begin errors++; $display("FAIL flush_state: got count %0d mask %h want 0/0", count, pending_mask); end
        checks++; if (load_stall !== 1'b0 || issue_ready !== 1'b1) begin errors++; $display("FAIL flush_stall: got stall %b ready %b want 0/1", load_stall, issue_ready); end
        checks++; if (resp_rd !== 5'd0) begin errors++; $display("FAIL flush_resp_rd: got %0d want 0", resp_rd); end
        has_rs1 = 1'b0; has_rs3 = 1'b0;
    endtask

    task automatic test_empty_resp();
        checks++; if (resp_err !== exp_err) begin errors++; $display("FAIL err_pre: got %b want %b", resp_err, exp_err); end
        tick(1'b0, 5'd0, 1'b1, 1'b0);
        checks++; if (count !== 3'd0 || resp_err !== exp_err) begin errors++; $display("FAIL err_set: got count %0d err %b want 0/%b", count, resp_err, exp_err); end
        tick(1'b1, 5'd12, 1'b0, 1'b0);
        checks++; if (count !== 3'd1 || resp_err !== exp_err) begin errors++; $display("FAIL err_sticky: got count %0d err %b want 1/%b", count, resp_err, exp_err); end
        tick(1'b0, 5'd0, 1'b0, 1'b1);
        checks++; if (resp_err !== exp_err) begin errors++; $display("FAIL err_flush: got %b want %b", resp_err, exp_err); end
        tick(1'b1, 5'd12, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        sb.delete();
        exp_err = 1'b0;
        #1;
        checks++; if (resp_err !== exp_err || count !== 3'd0) begin errors++; $display("FAIL async_reset: got err %b count %0d want %b/0", resp_err, count, exp_err); end
        checks++; if (pending_mask !== 32'h0 || issue_ready !== 1'b1) begin errors++; $display("FAIL async_reset_mask: got mask %h ready %b want 0/1", pending_mask, issue_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tick(1'b0, 5'd0, 1'b1, 1'b0);
        checks++; if (resp_err !== exp_err) begin errors++; $display("FAIL err_after_reset: got %b want %b", resp_err, exp_err); end
    endtask

    initial begin
        rst_n       = 1'b0;
        flush       = 1'b0;
        issue_valid = 1'b0;
        issue_rd    = '0;
        resp_valid  = 1'b0;
        has_rs1     = 1'b0;
        has_rs2     = 1'b0;
        has_rs3     = 1'b0;
        rs1_addr    = '0;
        rs2_addr    = '0;
        rs3_addr    = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        test_reset();
        test_issue_use();
        test_fill_drain();
        test_dup_x0();
        test_flush();
        test_empty_resp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
